// File: rtl/elevator_queue_ctrl.sv
// Four-level elevator sequencer: owns the request queue, walks the car one
// level at a time toward the head entry, pops on arrival and holds the door.
module elevator_queue_ctrl #(
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       add_new_lvl,
  input  logic [1:0] pressed_lvl,
  output logic [7:0] queue,
  output logic [2:0] tail,
  output logic       full,
  output logic [1:0] cur_lvl,
  output logic       moving,
  output logic       dir_up,
  output logic       door_open,
  output logic       btn_drop
);

  localparam int MAX_CYCLES = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int TIMER_W    = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] MOVE_LOAD = TIMER_W'(MOVE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DOOR_LOAD = TIMER_W'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [TIMER_W-1:0] timer_reg, timer_next;
  logic [7:0]         queue_reg, queue_next;
  logic [2:0]         tail_reg, tail_next;
  logic [1:0]         cur_lvl_reg, cur_lvl_next;
  logic               btn_drop_reg, btn_drop_next;

  logic [1:0] head;
  logic       pop;
  logic       absorbed;
  logic [7:0] queue_popped;
  logic [2:0] tail_popped;
  logic [3:0] entry_match;
  logic       duplicate;

  assign head = queue_reg[1:0];

  // Queue view after any same-edge pop; duplicate and capacity checks use it.
  assign queue_popped = pop ? {2'b00, queue_reg[7:2]} : queue_reg;
  assign tail_popped  = pop ? (tail_reg - 3'd1) : tail_reg;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_match
      assign entry_match[gi] = (queue_popped[2*gi +: 2] == pressed_lvl) &&
                               (tail_popped > 3'(gi));
    end
  endgenerate

  assign duplicate = |entry_match;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      timer_reg    <= '0;
      queue_reg    <= '0;
      tail_reg     <= '0;
      cur_lvl_reg  <= '0;
      btn_drop_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      queue_reg    <= queue_next;
      tail_reg     <= tail_next;
      cur_lvl_reg  <= cur_lvl_next;
      btn_drop_reg <= btn_drop_next;
    end
  end

  // Car motion, door timing and the pop decision.
  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    cur_lvl_next = cur_lvl_reg;
    pop          = 1'b0;
    absorbed     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (tail_reg != 3'd0) begin
          if (head == cur_lvl_reg) begin
            pop        = 1'b1;
            state_next = DOOR;
            timer_next = DOOR_LOAD;
          end else begin
            state_next = MOVE;
            timer_next = MOVE_LOAD;
          end
        end
      end
      MOVE: begin
        if (timer_reg != '0) begin
          timer_next = timer_reg - 1'b1;
        end else begin
          cur_lvl_next = dir_up ? (cur_lvl_reg + 2'd1) : (cur_lvl_reg - 2'd1);
          if (cur_lvl_next == head) begin
            pop        = 1'b1;
            state_next = DOOR;
            timer_next = DOOR_LOAD;
          end else begin
            timer_next = MOVE_LOAD;
          end
        end
      end
      DOOR: begin
        if (timer_reg != '0) begin
          timer_next = timer_reg - 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // A press for the level the car is (or will be) parked at opens or re-arms the door.
    absorbed = add_new_lvl && (pressed_lvl == cur_lvl_next) && (state_next != MOVE);
    if (absorbed) begin
      state_next = DOOR;
      timer_next = DOOR_LOAD;
    end
  end

  // Queue maintenance: pop first, then append the new request at the post-pop tail.
  always_comb begin
    queue_next    = queue_popped;
    tail_next     = tail_popped;
    btn_drop_next = 1'b0;

    if (add_new_lvl && !absorbed) begin
      if (duplicate || (tail_popped == 3'd4)) begin
        btn_drop_next = 1'b1;
      end else begin
        queue_next[{tail_popped[1:0], 1'b0} +: 2] = pressed_lvl;
        tail_next = tail_popped + 3'd1;
      end
    end
  end

  assign queue     = queue_reg;
  assign tail      = tail_reg;
  assign full      = (tail_reg == 3'd4);
  assign cur_lvl   = cur_lvl_reg;
  assign moving    = (state_reg == MOVE);
  assign dir_up    = (state_reg == MOVE) && (head > cur_lvl_reg);
  assign door_open = (state_reg == DOOR);
  assign btn_drop  = btn_drop_reg;

endmodule

// File: doc/elevator_queue_ctrl.md
Name: elevator_queue_ctrl

Overview:
- Sequences the 4-level elevator request queue: accepts button presses, appends to the queue with the same packed format as the queue add logic, moves the car one level at a time toward the head entry, and pops the head on arrival.
- On arrival it opens the door for a fixed time.
- Sits between the button inputs and the car/door actuators.
- Owns the queue and tail registers.

Parameters:
- MOVE_CYCLES, 4, clock cycles spent in MOVE per level travelled (>=1)
- DOOR_CYCLES, 3, clock cycles door_open is held high (>=1)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- add_new_lvl  input  1  button press valid this cycle
- pressed_lvl  input  2  requested level 0..3
- queue  output  8  packed queue; entry i at bits [2i+1:2i], entry 0 is head
- tail  output  3  number of valid entries, 0..4
- full  output  1  tail==4
- cur_lvl  output  2  current car level
- moving  output  1  high in MOVE
- dir_up  output  1  in MOVE, 1 = head>cur_lvl; 0 otherwise
- door_open  output  1  high in DOOR
- btn_drop  output  1  one-cycle pulse: press rejected (duplicate or full)

Behaviour:
- Clocking: one clock domain. Reset is synchronous, active-high.
- Reset values: queue=0, tail=0, cur_lvl=0, state=IDLE, timer=0. Outputs moving, dir_up, door_open, btn_drop are all 0.
- Reset mid-operation aborts any move or door and clears the queue. cur_lvl returns to 0.
- Press handling, evaluated in order at each edge when add_new_lvl=1:
  - a) If pressed_lvl==cur_lvl and next state is IDLE or DOOR: absorbed, no enqueue, btn_drop=0. The door opens or its timer restarts (see DOOR).
  - b) If pressed_lvl matches a valid entry (index < tail after any same-cycle pop): dropped, btn_drop=1.
  - c) If the post-pop tail==4: dropped, btn_drop=1.
  - d) Otherwise the entry at the post-pop tail is written and tail increments.
- Press to cur_lvl during MOVE is enqueued normally.
- Pop: queue shifts right by 2, the top entry is zero-filled, and tail decrements. A pop and an add in the same edge are both applied: pop first, then the write at tail-1.
- FSM, timer width = clog2(max(MOVE_CYCLES, DOOR_CYCLES)):
  - IDLE:
    - tail!=0 and head==cur_lvl: pop, go to DOOR, timer=DOOR_CYCLES-1.
    - tail!=0 and head!=cur_lvl: go to MOVE, timer=MOVE_CYCLES-1.
    - tail==0 and absorbed press: go to DOOR, timer=DOOR_CYCLES-1.
    - else stay.
  - MOVE:
    - timer!=0: timer decrements.
    - timer==0: cur_lvl = cur_lvl±1 per dir_up.
      - If the new cur_lvl==head: pop, go to DOOR, timer=DOOR_CYCLES-1.
      - Else reload timer=MOVE_CYCLES-1.
    - Head is stable in MOVE because pops only happen on arrival.
  - DOOR:
    - Absorbed press: timer=DOOR_CYCLES-1.
    - Else timer!=0: decrement.
    - Else timer==0: go to IDLE.
- Latency:
  - Press to queue visible: 1 cycle.
  - The FSM reacts one cycle after the queue update.
  - Each level takes MOVE_CYCLES cycles.
  - door_open stays high for exactly DOOR_CYCLES cycles absent extension.
- cur_lvl never wraps: it is driven only toward head, range 0..3.

Test Plan (MOVE_CYCLES=4, DOOR_CYCLES=3):
1. After reset, press 2 at edge k:
   - After k: queue=8'b00000010, tail=1.
   - After k+1: moving=1, dir_up=1.
   - After k+5: cur_lvl=1.
   - After k+9: cur_lvl=2, door_open=1, tail=0, queue=0.
   - After k+12: door_open=0, IDLE.
2. At level 0, press 3 at edge 0, then presses 1, 2, 0 at edges 2, 3, 4:
   - queue=8'b00100111, tail=4, full=1.
   - Press 1 at edge 5: btn_drop=1, queue unchanged.
3. Duplicate: with queue=[3], press 3 again -> btn_drop=1 for one cycle, tail stays 1.
4. Simultaneous pop+add:
   - Setup: queue=[1,3], moving up to 1; press 2 on the arrival edge.
   - Result: cur_lvl=1, queue=8'b00001011, tail=2.
   - Pressing 1 on the arrival edge instead: absorbed, btn_drop=0, tail=1.
5. Idle at level 0, press 0:
   - door_open=1 for 3 cycles, queue unchanged.
   - A repeat press of 0 on the 2nd door cycle extends door_open to 5 cycles total.
6. Reset asserted mid-MOVE, after cur_lvl=1 with queue=[3,2]:
   - Next edge: cur_lvl=0, queue=0, tail=0, moving=0, door_open=0.
